// File: rtl/uart_img_rx.sv
// rtl/uart_img_rx.sv - 8N1 UART receiver that buffers one image frame and replays it as a contiguous pixel burst
module uart_img_rx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int IMG_PIXELS  = 784,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] img_dout,
  output logic       dout_vld,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int AW           = $clog2(IMG_PIXELS);
  localparam int BW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_PIXELS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_RECV, F_SEND} f_state_t;

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_next;
  logic [BW-1:0]   baud_cnt, baud_next;
  logic [2:0]      bit_idx, bit_next;
  logic [7:0]      shreg, sh_next;
  logic            byte_vld, byte_vld_next;
  logic            stop_err, stop_err_next;

  f_state_t        f_state, f_next;
  logic [AW-1:0]   wptr, wptr_next, rptr, rptr_next, rd_addr;
  logic [TW-1:0]   tcnt, tcnt_next;
  logic            rd_active, rd_active_next;
  logic            wr_en, rd_en, rd_last, err_next;
  logic            rd_q, rd_last_q, dout_last;
  logic [7:0]      ram_q;
  logic [7:0]      mem [IMG_PIXELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      rx_state <= rx_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= sh_next;
      byte_vld <= byte_vld_next;
      stop_err <= stop_err_next;
    end
  end

  // Samples land mid-bit: half a bit after the start edge, then one bit apart.
  always_comb begin
    rx_next       = rx_state;
    baud_next     = baud_cnt;
    bit_next      = bit_idx;
    sh_next       = shreg;
    byte_vld_next = 1'b0;
    stop_err_next = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        baud_next = '0;
        if (rx_prev && !rx_sync) rx_next = RX_START;
      end
      RX_START: begin
        if (baud_cnt == BW'(HALF_BIT - 1)) begin
          baud_next = '0;
          bit_next  = '0;
          rx_next   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
          baud_next = '0;
          sh_next   = {rx_sync, shreg[7:1]};
          bit_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
          baud_next = '0;
          if (rx_sync) begin
            byte_vld_next = 1'b1;
            rx_next       = RX_IDLE;
          end else begin
            stop_err_next = 1'b1;
            rx_next       = RX_WAITHI;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      RX_WAITHI: begin
        if (rx_sync) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state    <= F_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      tcnt       <= '0;
      rd_active  <= 1'b0;
      rd_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      dout_last  <= 1'b0;
      dout_vld   <= 1'b0;
      img_dout   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      f_state    <= f_next;
      wptr       <= wptr_next;
      rptr       <= rptr_next;
      tcnt       <= tcnt_next;
      rd_active  <= rd_active_next;
      rd_q       <= rd_en;
      rd_last_q  <= rd_last;
      dout_last  <= rd_last_q;
      dout_vld   <= rd_q;
      if (rd_q) img_dout <= ram_q;
      frame_done <= dout_last;
      frame_err  <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  // tcnt counts cycles elapsed since the last accepted byte; the first read is
  // issued alongside the final write so the burst starts without a bubble.
  always_comb begin
    f_next         = f_state;
    wptr_next      = wptr;
    rptr_next      = rptr;
    tcnt_next      = tcnt;
    rd_active_next = rd_active;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    rd_addr        = rptr;
    err_next       = stop_err;
    unique case (f_state)
      F_IDLE: begin
        tcnt_next = '0;
        if (byte_vld) begin
          wr_en     = 1'b1;
          wptr_next = AW'(1);
          tcnt_next = TW'(1);
          f_next    = F_RECV;
        end
      end
      F_RECV: begin
        if (byte_vld) begin
          wr_en     = 1'b1;
          tcnt_next = TW'(1);
          if (wptr == LAST_ADDR) begin
            rd_en          = 1'b1;
            rd_addr        = '0;
            rptr_next      = AW'(1);
            rd_active_next = 1'b1;
            wptr_next      = '0;
            f_next         = F_SEND;
          end else begin
            wptr_next = wptr + 1'b1;
          end
        end else if (stop_err) begin
          f_next    = F_IDLE;
          wptr_next = '0;
          tcnt_next = '0;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          err_next  = 1'b1;
          f_next    = F_IDLE;
          wptr_next = '0;
          tcnt_next = '0;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      F_SEND: begin
        if (byte_vld) err_next = 1'b1;
        if (rd_active) begin
          rd_en = 1'b1;
          if (rptr == LAST_ADDR) begin
            rd_active_next = 1'b0;
            rptr_next      = '0;
          end else begin
            rptr_next = rptr + 1'b1;
          end
        end
        if (frame_done) f_next = F_IDLE;
      end
      default: f_next = F_IDLE;
    endcase
  end

  assign rd_last = rd_en && (rd_addr == LAST_ADDR);
  assign busy    = (f_state != F_IDLE);

endmodule

// File: tb/tb_uart_img_rx.sv
// tb/tb_uart_img_rx.sv - self-checking bench for uart_img_rx with a frame-level reference model
module tb_uart_img_rx;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int IMG      = 20;
  localparam int TO       = 500;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] img_dout;
  logic       dout_vld, frame_done, frame_err, busy;

  uart_img_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IMG_PIXELS(IMG), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .img_dout(img_dout),
    .dout_vld(dout_vld), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Output monitor
  logic [7:0] got_q[$];
  int cyc = 0, last_bv = 0, last_err_cyc = 0, rise_gap = 0;
  int run_len = 0, last_run = 0, err_cnt = 0, done_cnt = 0;
  logic prev_vld = 1'b0, prev_done = 1'b0, done_ok = 1'b0, busy_after = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (dut.byte_vld) last_bv = cyc;
    if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
    if (dout_vld) begin
      if (!prev_vld) begin run_len = 0; rise_gap = cyc - last_bv; end
      got_q.push_back(img_dout);
      run_len++;
    end else if (prev_vld) begin
      last_run = run_len;
    end
    if (frame_done) begin done_cnt++; done_ok = prev_vld && !dout_vld && busy; end
    if (prev_done) busy_after = busy;
    prev_vld  = dout_vld;
    prev_done = frame_done;
  end

  // Reference model: bytes accepted since the last abort; a full set becomes the expected burst
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int model_err = 0, exp_frames = 0;

  task automatic uart_bit(logic b);
    uart_rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, logic stop);
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(stop);
    uart_rxd = 1'b1;
    if (stop) begin
      model_q.push_back(b);
      if (model_q.size() == IMG) begin
        exp_q = model_q;
        model_q.delete();
        exp_frames++;
      end
    end else begin
      model_q.delete();
      model_err++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
    if (n > TO && model_q.size() != 0) begin
      model_q.delete();
      model_err++;
    end
  endtask

  task automatic send_frame(logic [7:0] base);
    for (int i = 0; i < IMG; i++) begin
      send_byte(8'(base + i), 1'b1);
      idle($urandom_range(0, 20));
    end
  endtask

  task automatic wait_frame(int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_burst(string tag);
    int mism;
    mism = 0;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_pix_mismatches"}, mism, 0);
    check({tag, "_run_len"}, last_run, IMG);
    check({tag, "_rise_latency"}, rise_gap, 2);
    check({tag, "_done_after_last"}, done_ok, 1);
    check({tag, "_busy_after_done"}, busy_after, 0);
  endtask

  typedef struct {
    int         kind;     // 0 plain, 1 bad stop at pos, 2 timeout after pos, 3 glitch
    int         pos;
    logic [7:0] base;
    int         exp_err;
  } vec_t;

  vec_t vt[5];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0, e0, m0, f0, bad_ff;
    logic [7:0] rb;
    logic       rbad;

    vt[0] = '{0, 0,  8'd0,   0};
    vt[1] = '{1, 10, 8'd40,  1};
    vt[2] = '{2, 5,  8'd100, 1};
    vt[3] = '{3, 0,  8'd200, 0};
    vt[4] = '{0, 0,  8'd236, 0};

    repeat (10) @(negedge clk);
    check("rst_outputs", {img_dout, dout_vld, frame_done, frame_err, busy}, 0);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    check("idle_no_dout", got_q.size(), 0);
    check("idle_no_err", err_cnt, 0);
    check("idle_no_done", done_cnt, 0);
    check("idle_busy", busy, 0);

    for (int s = 0; s < 5; s++) begin
      d0 = done_cnt; e0 = err_cnt;
      got_q.delete();
      case (vt[s].kind)
        1: begin
          for (int i = 0; i < vt[s].pos; i++) begin send_byte(8'(i + 7), 1'b1); idle(3); end
          send_byte(8'h5A, 1'b0);
          idle(CPB);
          check("ferr_busy", busy, 0);
          check("ferr_no_dout", got_q.size(), 0);
        end
        2: begin
          for (int i = 0; i < vt[s].pos; i++) begin send_byte(8'(i + 3), 1'b1); idle(2); end
          idle(2 * TO);
          check("timeout_delay", last_err_cyc - last_bv, TO);
          check("timeout_busy", busy, 0);
          check("timeout_no_dout", got_q.size(), 0);
        end
        3: begin
          uart_rxd = 1'b0;
          repeat (3) @(negedge clk);
          uart_rxd = 1'b1;
          idle(40);
          check("glitch_busy", busy, 0);
          check("glitch_err", err_cnt - e0, 0);
        end
        default: ;
      endcase
      send_frame(vt[s].base);
      wait_frame(d0);
      check_burst("vec");
      check("vec_err_count", err_cnt - e0, vt[s].exp_err);
    end

    for (int f = 0; f < 3; f++) begin
      d0 = done_cnt; e0 = err_cnt; m0 = model_err; f0 = exp_frames;
      got_q.delete();
      while (exp_frames == f0) begin
        rb   = 8'($urandom);
        rbad = ($urandom_range(0, 24) == 0);
        send_byte(rb, !rbad);
        idle(rbad ? CPB : $urandom_range(0, 30));
      end
      wait_frame(d0);
      check_burst("rand");
      check("rand_err_count", err_cnt - e0, model_err - m0);
    end

    for (int i = 0; i < 7; i++) begin send_byte(8'(i + 90), 1'b1); idle(2); end
    uart_rxd = 1'b0;
    repeat (3 * CPB + 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {img_dout, dout_vld, frame_done, frame_err, busy}, 0);
    uart_rxd = 1'b1;
    model_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    got_q.delete();
    for (int i = 0; i < IMG; i++) begin send_byte(8'hFF, 1'b1); idle($urandom_range(0, 10)); end
    wait_frame(d0);
    bad_ff = 0;
    foreach (got_q[i]) if (got_q[i] !== 8'hFF) bad_ff++;
    check("midrst_ff_count", got_q.size(), IMG);
    check("midrst_ff_values", bad_ff, 0);
    check_burst("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
